port_reg_arbiter: RTL and testbench
===================================

// Module: port_reg_arbiter
// PURPOSE
//  Shares one switch register/statistics write bus between N MAC ports. Each mac_top
//  instance drives a port_addr/port_din/port_req, port_ack handshake. Grants are
//  round-robin; one transfer is in flight at a time. A watchdog aborts any transfer
//  the downstream register unit never acknowledges.
// PARAMETERS
//  N_PORT   4     number of requesting MAC ports (2..16)
//  AW       7     register address width (matches port_addr)
//  DW       16    register data width (matches port_din)
//  TIMEOUT  255   max cycles m_req may stay high without m_ack before abort (1..65535)
// PORTS
//  clk        in   1         system clock; single clock domain
//  rstn_sys   in   1         synchronous, active-low reset
//  port_req   in   N_PORT    per-port request; held high with addr/din stable until ack
//  port_addr  in   N_PORT*AW packed addresses, port i at [i*AW +: AW]
//  port_din   in   N_PORT*DW packed data, port i at [i*DW +: DW]
//  port_ack   out  N_PORT    one-cycle completion pulse to the granted port
//  m_req      out  1         downstream request, level, held until m_ack or abort
//  m_addr     out  AW        registered address of granted port
//  m_din      out  DW        registered data of granted port
//  m_ack      in   1         downstream accept, single-cycle pulse
//  err_pulse  out  1         one-cycle pulse on watchdog abort
//  err_cnt    out  16        saturating count of aborts
// BEHAVIOUR
//  Reset (rstn_sys low at a clk edge): state=IDLE, rr_ptr=0, port_ack=0, m_req=0,
//   m_addr=0, m_din=0, err_pulse=0, err_cnt=0, wdog=0. Reset mid-transfer drops
//   m_req next edge; no ack is issued to the interrupted port.
//  FSM: IDLE -> GRANT -> ACK -> RELEASE -> IDLE.
//   IDLE: if any port_req, pick first requesting index at or after rr_ptr (modulo
//    N_PORT); latch gnt, m_addr, m_din; m_req=1 next cycle; -> GRANT. Else stay.
//   GRANT: m_req=1, m_addr/m_din constant. wdog increments each cycle.
//    m_ack=1 -> ACK (m_req=0 next cycle). wdog reaches TIMEOUT without m_ack ->
//    ACK with err_pulse=1, err_cnt+1 (saturates at 16'hFFFF). m_ack in the same
//    cycle as timeout counts as success (no error).
//   ACK: port_ack[gnt]=1 for exactly this cycle; rr_ptr=gnt+1 (wrap to 0 after
//    N_PORT-1); -> RELEASE.
//   RELEASE: one dead cycle; all port_req ignored (requester drops req here);
//    wdog=0; -> IDLE.
//  Latency: req sampled in IDLE at t -> m_req at t+1; m_ack at t+k -> port_ack
//   at t+k+1; earliest next grant sampled t+k+3. Throughput 1 write per 4 cycles
//   at zero downstream wait.
//  port_req dropped by a port while granted: transfer still completes and is acked.
//  m_ack outside GRANT is ignored. Only one bit of port_ack ever high.
//  Simultaneous requests: lowest index at/after rr_ptr wins; a continuously
//   requesting port waits at most N_PORT-1 transfers.
// STRUCTURE
//  Shared package switch_pkg: state encoding (IDLE/GRANT/ACK/RELEASE), register
//   address constants PORT_RX_ADDR=7'h10, PORT_TX_ADDR=7'h11, PORT_ER_ADDR=7'h12.
//  One sub-module: rr_pick (combinational N_PORT round-robin priority picker:
//   req vector + ptr -> gnt index + valid). FSM, watchdog, counters in top.
// TESTING
//  1 Single: port2 req addr=7'h11 din=16'h00A5, m_ack 3 cycles after m_req ->
//    m_addr=7'h11 m_din=16'h00A5, port_ack=4'b0100 one cycle, err_cnt=0.
//  2 Fairness: all 4 ports hold req, m_ack immediate -> grant order 0,1,2,3,0;
//    each port_ack spaced 4 cycles apart.
//  3 Timeout: TIMEOUT=8, m_ack never -> m_req high 8 cycles then low, err_pulse
//    once, err_cnt=1, port_ack still issued to requester.
//  4 Boundary: m_ack in the cycle wdog hits TIMEOUT -> no err_pulse, err_cnt unchanged;
//    force err_cnt=16'hFFFF then abort -> stays 16'hFFFF.
//  5 Reset mid-GRANT: rstn_sys low while m_req=1 -> next edge m_req=0, no port_ack,
//    rr_ptr=0; after release, port0 and port3 req -> port0 granted first.
//  6 Stray m_ack in IDLE/RELEASE and req drop during GRANT -> no extra port_ack;
//    dropped-req transfer still acked exactly once.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared definitions for the switch register-bus arbiter: FSM encoding,
// register address map and small helper functions.
package switch_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // Per-port statistics register addresses
    localparam logic [6:0] PORT_RX_ADDR = 7'h10;
    localparam logic [6:0] PORT_TX_ADDR = 7'h11;
    localparam logic [6:0] PORT_ER_ADDR = 7'h12;

    // Next round-robin pointer: one past the last winner, wrapping at n
    function automatic int rr_next(input int gnt, input int n);
        return (gnt + 1 >= n) ? 0 : gnt + 1;
    endfunction

    // 16-bit counter increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/port_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr,
// searching upward modulo N_PORT.
module rr_pick #(
    parameter int N_PORT = 4,
    parameter int PW     = $clog2(N_PORT)
) (
    input  logic [N_PORT-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [PW-1:0]     gnt,
    output logic              valid
);

    logic [PW-1:0] cand;

    // Scan from ptr upward; the first hit wins
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_PORT; i++) begin
            cand = PW'((int'(ptr) + i) % N_PORT);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                gnt   = cand;
            end
        end
    end

endmodule

// File: rtl/port_reg_arbiter.sv
// Round-robin arbiter sharing one register write bus between N MAC ports.
// One transfer in flight; a watchdog aborts transfers that are never acked.
module port_reg_arbiter
    import switch_pkg::*;
#(
    parameter int N_PORT  = 4,
    parameter int AW      = 7,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rstn_sys,
    input  logic [N_PORT-1:0]    port_req,
    input  logic [N_PORT*AW-1:0] port_addr,
    input  logic [N_PORT*DW-1:0] port_din,
    output logic [N_PORT-1:0]    port_ack,
    output logic                 m_req,
    output logic [AW-1:0]        m_addr,
    output logic [DW-1:0]        m_din,
    input  logic                 m_ack,
    output logic                 err_pulse,
    output logic [15:0]          err_cnt
);

    localparam int PW = $clog2(N_PORT);

    logic [1:0]        state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     gnt_q, gnt_d;
    logic              m_req_q, m_req_d;
    logic [AW-1:0]     m_addr_q, m_addr_d;
    logic [DW-1:0]     m_din_q, m_din_d;
    logic [N_PORT-1:0] port_ack_q, port_ack_d;
    logic              err_pulse_q, err_pulse_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [15:0]       wdog_q, wdog_d;

    logic [PW-1:0]     pick_idx;
    logic              pick_vld;

    rr_pick #(
        .N_PORT (N_PORT),
        .PW     (PW)
    ) u_rr_pick (
        .req   (port_req),
        .ptr   (rr_ptr_q),
        .gnt   (pick_idx),
        .valid (pick_vld)
    );

    // Next-state logic: grant, wait for ack or watchdog, ack requester, dead cycle
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        m_req_d     = m_req_q;
        m_addr_d    = m_addr_q;
        m_din_d     = m_din_q;
        port_ack_d  = '0;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        wdog_d      = wdog_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_d    = pick_idx;
                    m_addr_d = port_addr[int'(pick_idx)*AW +: AW];
                    m_din_d  = port_din[int'(pick_idx)*DW +: DW];
                    m_req_d  = 1'b1;
                    wdog_d   = '0;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // An ack arriving on the timeout cycle still counts as success
                if (m_ack) begin
                    m_req_d           = 1'b0;
                    port_ack_d[gnt_q] = 1'b1;
                    state_d           = ST_ACK;
                end else if (wdog_q == 16'(TIMEOUT - 1)) begin
                    m_req_d           = 1'b0;
                    port_ack_d[gnt_q] = 1'b1;
                    err_pulse_d       = 1'b1;
                    err_cnt_d         = sat_inc16(err_cnt_q);
                    wdog_d            = wdog_q + 16'd1;
                    state_d           = ST_ACK;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            ST_ACK: begin
                rr_ptr_d = PW'(rr_next(int'(gnt_q), N_PORT));
                state_d  = ST_RELEASE;
            end
            ST_RELEASE: begin
                wdog_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn_sys) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            m_req_q     <= 1'b0;
            m_addr_q    <= '0;
            m_din_q     <= '0;
            port_ack_q  <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            m_req_q     <= m_req_d;
            m_addr_q    <= m_addr_d;
            m_din_q     <= m_din_d;
            port_ack_q  <= port_ack_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            wdog_q      <= wdog_d;
        end
    end

    assign port_ack  = port_ack_q;
    assign m_req     = m_req_q;
    assign m_addr    = m_addr_q;
    assign m_din     = m_din_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_port_reg_arbiter.sv
// Directed bench for port_reg_arbiter: single transfer, fairness, watchdog,
// boundary cases, reset mid-transfer and stray acks.
module tb_port_reg_arbiter;
    import switch_pkg::*;

    localparam int NP = 4;
    localparam int AW = 7;
    localparam int DW = 16;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rstn_sys;
    logic [NP-1:0]    port_req;
    logic [NP*AW-1:0] port_addr;
    logic [NP*DW-1:0] port_din;
    logic [NP-1:0]    port_ack;
    logic             m_req;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_din;
    logic             m_ack;
    logic             err_pulse;
    logic [15:0]      err_cnt;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    port_reg_arbiter #(
        .N_PORT  (NP),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rstn_sys  (rstn_sys),
        .port_req  (port_req),
        .port_addr (port_addr),
        .port_din  (port_din),
        .port_ack  (port_ack),
        .m_req     (m_req),
        .m_addr    (m_addr),
        .m_din     (m_din),
        .m_ack     (m_ack),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        port_addr[i*AW +: AW] = a;
        port_din[i*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        rstn_sys = 1'b0;
        tick();
        tick();
        rstn_sys = 1'b1;
    endtask

    // Count cycles m_req stays high from now, bounded
    task automatic count_mreq(output int cnt);
        int guard;
        cnt   = 0;
        guard = 0;
        while (m_req === 1'b1 && guard < 40) begin
            cnt++;
            guard++;
            tick();
        end
    endtask

    int cnt;
    int t_prev;
    int exp_port;

    initial begin
        rstn_sys  = 1'b0;
        port_req  = '0;
        port_addr = '0;
        port_din  = '0;
        m_ack     = 1'b0;
        set_port(0, PORT_RX_ADDR, 16'h1000);
        set_port(1, PORT_TX_ADDR, 16'h1001);
        set_port(2, PORT_ER_ADDR, 16'h1002);
        set_port(3, 7'h13,        16'h1003);
        do_reset();

        // Reset state
        chk("rst_mreq",   32'(m_req),     32'h0);
        chk("rst_ack",    32'(port_ack),  32'h0);
        chk("rst_maddr",  32'(m_addr),    32'h0);
        chk("rst_mdin",   32'(m_din),     32'h0);
        chk("rst_errp",   32'(err_pulse), 32'h0);
        chk("rst_errcnt", 32'(err_cnt),   32'h0);

        // 1: single transfer from port2, ack three cycles after m_req
        set_port(2, 7'h11, 16'h00A5);
        port_req = 4'b0100;
        tick();
        chk("t1_mreq",  32'(m_req),  32'h1);
        chk("t1_maddr", 32'(m_addr), 32'h11);
        chk("t1_mdin",  32'(m_din),  32'h00A5);
        tick();
        tick();
        chk("t1_mreq_hold", 32'(m_req), 32'h1);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("t1_ack",   32'(port_ack),  32'h4);
        chk("t1_mreq0", 32'(m_req),     32'h0);
        chk("t1_errp",  32'(err_pulse), 32'h0);
        port_req = '0;
        tick();
        chk("t1_ack_1cyc", 32'(port_ack), 32'h0);
        tick();
        chk("t1_errcnt", 32'(err_cnt), 32'h0);
        set_port(2, PORT_ER_ADDR, 16'h1002);

        // 2: fairness with all ports requesting, immediate ack
        do_reset();
        port_req = 4'b1111;
        t_prev   = 0;
        for (int k = 0; k < 5; k++) begin
            exp_port = k % NP;
            tick();
            chk("t2_mdin", 32'(m_din), 32'h1000 + 32'(exp_port));
            m_ack = 1'b1;
            tick();
            m_ack = 1'b0;
            chk("t2_ack", 32'(port_ack), 32'(1 << exp_port));
            if (k > 0) chk("t2_space", 32'(cyc - t_prev), 32'd4);
            t_prev = cyc;
            tick();
            tick();
        end
        port_req = '0;

        // 3: watchdog abort, port1 (pointer now 1)
        port_req = 4'b0010;
        tick();
        count_mreq(cnt);
        chk("t3_mreq_cycles", 32'(cnt),       32'd8);
        chk("t3_ack",         32'(port_ack),  32'h2);
        chk("t3_errp",        32'(err_pulse), 32'h1);
        chk("t3_errcnt",      32'(err_cnt),   32'h1);
        port_req = '0;
        tick();
        chk("t3_errp_1cyc", 32'(err_pulse), 32'h0);
        tick();

        // 4a: ack on the timeout cycle is a success, port2
        port_req = 4'b0100;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        chk("t4_mreq_late", 32'(m_req), 32'h1);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("t4_ack",    32'(port_ack),  32'h4);
        chk("t4_errp",   32'(err_pulse), 32'h0);
        chk("t4_errcnt", 32'(err_cnt),   32'h1);
        port_req = '0;
        tick();
        tick();

        // 4b: error counter saturates, port3
        force dut.err_cnt_q = 16'hFFFF;
        tick();
        release dut.err_cnt_q;
        chk("t4_forced", 32'(err_cnt), 32'hFFFF);
        port_req = 4'b1000;
        tick();
        count_mreq(cnt);
        chk("t4_sat_ack",  32'(port_ack),  32'h8);
        chk("t4_sat_errp", 32'(err_pulse), 32'h1);
        chk("t4_sat_cnt",  32'(err_cnt),   32'hFFFF);
        port_req = '0;
        tick();
        tick();

        // 5: reset mid-GRANT; move pointer to 3 first so reset clearing it is visible
        port_req = 4'b0100;
        tick();
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        port_req = '0;
        tick();
        tick();
        port_req = 4'b0010;
        tick();
        chk("t5_mreq", 32'(m_req), 32'h1);
        rstn_sys = 1'b0;
        tick();
        chk("t5_rst_mreq",   32'(m_req),    32'h0);
        chk("t5_rst_ack",    32'(port_ack), 32'h0);
        chk("t5_rst_errcnt", 32'(err_cnt),  32'h0);
        port_req = 4'b1001;
        tick();
        chk("t5_rst_ack2", 32'(port_ack), 32'h0);
        rstn_sys = 1'b1;
        tick();
        chk("t5_mreq2", 32'(m_req),  32'h1);
        chk("t5_addr0", 32'(m_addr), 32'(PORT_RX_ADDR));
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("t5_ack0", 32'(port_ack), 32'h1);
        port_req = '0;
        tick();
        tick();

        // 6: stray m_ack in IDLE, req dropped during GRANT, m_ack held through ACK/RELEASE
        m_ack = 1'b1;
        tick();
        chk("t6_idle_ack", 32'(port_ack), 32'h0);
        chk("t6_idle_req", 32'(m_req),    32'h0);
        tick();
        chk("t6_idle_ack2", 32'(port_ack), 32'h0);
        m_ack    = 1'b0;
        port_req = 4'b0100;
        tick();
        port_req = '0;
        chk("t6_mreq", 32'(m_req), 32'h1);
        tick();
        m_ack = 1'b1;
        tick();
        chk("t6_ack_once", 32'(port_ack), 32'h4);
        tick();
        chk("t6_rel_ack", 32'(port_ack), 32'h0);
        tick();
        chk("t6_idle2_ack", 32'(port_ack), 32'h0);
        chk("t6_idle2_req", 32'(m_req),    32'h0);
        m_ack = 1'b0;
        tick();
        chk("t6_end_ack", 32'(port_ack), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
